// File: rtl/wb_stage.sv
// wb_stage: writeback stage with load extraction, busy scoreboard and optional WB_BYPASS_EN forwarding.
module wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_wen,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_result,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] R1,
  input  logic [31:0] R2,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        rs1_busy,
  output logic        rs2_busy
);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;
  state_t      r_state;
  logic [4:0]  r_rd;
  logic        r_wen;
  logic [2:0]  r_funct3;
  logic [1:0]  r_addr_lo;
  logic [4:0]  r_rf_rd;
  logic [31:0] r_rf_wdata;
  logic [31:0] r_busy;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;
  logic [31:0] w_set;
  logic [31:0] w_clr;
  logic        w_hit1;
  logic        w_hit2;
  always_comb begin
    in_ready = !rst && r_state != WAIT_MEM;
    rf_wen   = r_state == WRITE && r_wen && r_rd != 5'd0;
    rf_rd    = r_rf_rd;
    rf_wdata = r_rf_wdata;
    w_byte   = mem_rdata[{r_addr_lo, 3'b000} +: 8];
    w_half   = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_ld     = r_funct3 == 3'b000 ? {{24{w_byte[7]}}, w_byte} :
               r_funct3 == 3'b001 ? {{16{w_half[15]}}, w_half} :
               r_funct3 == 3'b100 ? {24'd0, w_byte} :
               r_funct3 == 3'b101 ? {16'd0, w_half} : mem_rdata;
    w_set    = (iss_valid && iss_rd != 5'd0) ? 32'd1 << iss_rd : 32'd0;
    w_clr    = r_state == WRITE ? 32'd1 << r_rd : 32'd0;
`ifdef WB_BYPASS_EN
    w_hit1   = rf_wen && rf_rd == rs1 && rs1 != 5'd0;
    w_hit2   = rf_wen && rf_rd == rs2 && rs2 != 5'd0;
`else
    w_hit1   = 1'b0;
    w_hit2   = 1'b0;
`endif
    rs1_data = w_hit1 ? rf_wdata : R1;
    rs2_data = w_hit2 ? rf_wdata : R2;
    rs1_busy = r_busy[rs1] && !w_hit1;
    rs2_busy = r_busy[rs2] && !w_hit2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rd       <= 5'd0;
      r_wen      <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr_lo  <= 2'd0;
      r_rf_rd    <= 5'd0;
      r_rf_wdata <= 32'd0;
      r_busy     <= 32'd0;
    end else begin
      // set after clear so a same-edge reissue keeps the bit
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
      if (in_valid && in_ready) begin
        r_rd      <= in_rd;
        r_wen     <= in_wen;
        r_funct3  <= in_funct3;
        r_addr_lo <= in_addr_lo;
        if (in_is_load) r_state <= WAIT_MEM;
        else begin
          r_state    <= WRITE;
          r_rf_rd    <= in_rd;
          r_rf_wdata <= in_result;
        end
      end else if (r_state == WAIT_MEM && mem_rvalid) begin
        r_state    <= WRITE;
        r_rf_rd    <= r_rd;
        r_rf_wdata <= w_ld;
      end else if (r_state == WRITE) r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed stimulus with a write scoreboard for wb_stage.
module tb_wb_stage;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready;
  logic [4:0]  in_rd = 0;
  logic        in_wen = 0, in_is_load = 0;
  logic [2:0]  in_funct3 = 0;
  logic [1:0]  in_addr_lo = 0;
  logic [31:0] in_result = 0;
  logic        mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        iss_valid = 0;
  logic [4:0]  iss_rd = 0, rs1 = 0, rs2 = 0;
  logic [31:0] R1 = 0, R2 = 0;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  int checks = 0, failures = 0;
  logic [36:0] sb_q[$];
  logic [36:0] sb_e;
  wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_wen(in_wen), .in_is_load(in_is_load), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_result(in_result), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rf_wen(rf_wen),
    .rf_rd(rf_rd), .rf_wdata(rf_wdata), .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1),
    .rs2(rs2), .R1(R1), .R2(R2), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );
  always #5 clk = ~clk;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [4:0] rd, input logic wen, input logic ld, input logic [2:0] f3,
                      input logic [1:0] lo, input logic [31:0] res);
    in_valid = 1; in_rd = rd; in_wen = wen; in_is_load = ld; in_funct3 = f3; in_addr_lo = lo; in_result = res;
  endtask
  always @(negedge clk) begin
    if (!rst && rf_wen) begin
      if (sb_q.size() == 0) chk("unexpected_write", {27'd0, rf_rd}, 32'hFFFFFFFF);
      else begin
        sb_e = sb_q.pop_front();
        chk("sb_rd", {27'd0, rf_rd}, {27'd0, sb_e[36:32]});
        chk("sb_data", rf_wdata, sb_e[31:0]);
      end
    end
  end
  initial begin
    step(); step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    rst = 0;
    #1;
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
    // ALU write to rd=5
    iss_valid = 1; iss_rd = 5; rs1 = 5;
    step();
    iss_valid = 0;
    chk("busy5_set", {31'd0, rs1_busy}, 32'd1);
    send(5, 1, 0, 0, 0, 32'h1234); sb_q.push_back({5'd5, 32'h1234});
    step();
    in_valid = 0;
    #1;
    chk("alu_wen", {31'd0, rf_wen}, 32'd1);
    chk("alu_wdata", rf_wdata, 32'h1234);
    chk("busy5_write", {31'd0, rs1_busy}, BYP ? 32'd0 : 32'd1);
    step();
    chk("busy5_clr", {31'd0, rs1_busy}, 32'd0);
    chk("idle_wen", {31'd0, rf_wen}, 32'd0);
    chk("hold_rd", {27'd0, rf_rd}, 32'd5);
    chk("hold_wdata", rf_wdata, 32'h1234);
    // stray mem_rvalid in IDLE does nothing
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_rvalid = 0;
    chk("stray_rvalid", {31'd0, rf_wen}, 32'd0);
    // LB with three wait cycles
    send(3, 1, 1, 3'b000, 2, 0); sb_q.push_back({5'd3, 32'hFFFFFF80});
    step();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("lb_wait_ready", {31'd0, in_ready}, 32'd0);
      chk("lb_wait_wen", {31'd0, rf_wen}, 32'd0);
      step();
    end
    mem_rvalid = 1; mem_rdata = 32'h0080FF00;
    #1;
    chk("lb_rv_ready", {31'd0, in_ready}, 32'd0);
    step();
    mem_rvalid = 0;
    chk("lb_wen", {31'd0, rf_wen}, 32'd1);
    chk("lb_data", rf_wdata, 32'hFFFFFF80);
    step();
    // LHU, LH and full word
    send(4, 1, 1, 3'b101, 2, 0); sb_q.push_back({5'd4, 32'h00008001});
    step();
    in_valid = 0; mem_rvalid = 1; mem_rdata = 32'h80010000;
    step();
    mem_rvalid = 0;
    chk("lhu_data", rf_wdata, 32'h00008001);
    send(8, 1, 1, 3'b001, 0, 0); sb_q.push_back({5'd8, 32'hFFFF8001});
    step();
    in_valid = 0; mem_rvalid = 1; mem_rdata = 32'h12348001;
    step();
    mem_rvalid = 0;
    chk("lh_data", rf_wdata, 32'hFFFF8001);
    send(10, 1, 1, 3'b110, 1, 0); sb_q.push_back({5'd10, 32'hA5A5_0F0F});
    step();
    in_valid = 0; mem_rvalid = 1; mem_rdata = 32'hA5A5_0F0F;
    step();
    mem_rvalid = 0;
    chk("word_data", rf_wdata, 32'hA5A50F0F);
    step();
    // rd=0 suppresses the write and leaves busy alone
    iss_valid = 1; iss_rd = 9; rs1 = 9; rs2 = 0;
    step();
    iss_valid = 0;
    send(0, 1, 0, 0, 0, 32'hDEAD);
    step();
    in_valid = 0;
    chk("rd0_wen", {31'd0, rf_wen}, 32'd0);
    chk("rd0_wdata", rf_wdata, 32'hDEAD);
    step();
    chk("rd0_busy9", {31'd0, rs1_busy}, 32'd1);
    chk("rd0_busy0", {31'd0, rs2_busy}, 32'd0);
    // back-to-back ALU results write every cycle
    send(1, 1, 0, 0, 0, 32'hAAAA0001); sb_q.push_back({5'd1, 32'hAAAA0001});
    step();
    chk("b2b_ready", {31'd0, in_ready}, 32'd1);
    send(2, 1, 0, 0, 0, 32'hBBBB0002); sb_q.push_back({5'd2, 32'hBBBB0002});
    step();
    in_valid = 0;
    chk("b2b_wen", {31'd0, rf_wen}, 32'd1);
    chk("b2b_rd", {27'd0, rf_rd}, 32'd2);
    step();
    // reissue of rd=7 on its own WRITE edge
    iss_valid = 1; iss_rd = 7;
    step();
    iss_valid = 0;
    send(7, 1, 0, 0, 0, 32'h77); sb_q.push_back({5'd7, 32'h77});
    step();
    in_valid = 0; iss_valid = 1; iss_rd = 7; rs1 = 7; R1 = 32'h1111;
    #1;
    chk("byp_data", rs1_data, BYP ? 32'h77 : 32'h1111);
    chk("byp_busy", {31'd0, rs1_busy}, BYP ? 32'd0 : 32'd1);
    step();
    iss_valid = 0;
    chk("set_wins", {31'd0, rs1_busy}, 32'd1);
    chk("post_data", rs1_data, 32'h1111);
    // reset while waiting on memory
    send(6, 1, 1, 3'b010, 0, 0);
    step();
    in_valid = 0; rst = 1;
    #1;
    chk("rst_ready_low", {31'd0, in_ready}, 32'd0);
    step();
    rst = 0; mem_rvalid = 1; mem_rdata = 32'h5555AAAA;
    step();
    mem_rvalid = 0;
    chk("rst_no_wen", {31'd0, rf_wen}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy7", {31'd0, rs1_busy}, 32'd0);
    rs1 = 9;
    #1;
    chk("rst_busy9", {31'd0, rs1_busy}, 32'd0);
    step();
    chk("rst_idle_wen", {31'd0, rf_wen}, 32'd0);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
